div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 27 ++
 rtl/div_unit_adder.sv | 19 +
 rtl/div_unit.sv | 189 ++++++++++++++++++
 tb/tb_div_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : div_unit_pkg                                               |
// | Description : Shared divider types: op encoding and control-FSM states.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package div_unit_pkg;

    // bit0 = unsigned, bit1 = remainder
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    localparam int c_op_unsigned_bit = 0;
    localparam int c_op_rem_bit      = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage
`default_nettype wire

// File: rtl/div_unit_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : div_unit_adder                                             |
// | Description : Generic W-bit adder with carry-in from the arithmetic lib. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module div_unit_adder #(
    parameter int W = 33
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_c_in,
    output logic [W-1:0] o_sum
);

    assign o_sum = i_a + i_b + W'(i_c_in);

endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : div_unit                                                   |
// | Description : Iterative radix-2 restoring divider, DIV/DIVU/REM/REMU,    |
// |               valid/ready handshake on both sides.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module div_unit
    import div_unit_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   div_control,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         div_by_zero_flag
);

    localparam int               c_cnt_w   = $clog2(N) + 1;
    localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(N - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [N-1:0]     c_one     = N'(1);
    localparam logic [N-1:0]     c_min     = {1'b1, {(N-1){1'b0}}};

    div_state_e         r_state;
    div_state_e         w_next_state;

    logic [N-1:0]       r_rem;
    logic [N-1:0]       r_quo;
    logic [N-1:0]       r_div;
    logic [N-1:0]       r_result;
    logic               r_dbz;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_is_rem;
    logic [c_cnt_w-1:0] r_count;

    logic               w_accept;
    logic               w_signed;
    logic               w_rem_op;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [N-1:0]       w_a_mag;
    logic [N-1:0]       w_b_mag;
    logic               w_b_zero;
    logic               w_ovf;
    logic               w_special;
    logic [N-1:0]       w_special_result;
    logic               w_last;

    logic [N:0]         w_shifted;
    logic [N:0]         w_trial;
    logic               w_q_bit;
    logic [N-1:0]       w_rem_next;
    logic [N-1:0]       w_quo_next;
    logic [N-1:0]       w_fix_result;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign in_ready  = (r_state == ST_IDLE) & ~rst;
    assign w_accept  = in_valid & in_ready;

    assign w_signed  = ~div_control[c_op_unsigned_bit];
    assign w_rem_op  = div_control[c_op_rem_bit];
    assign w_a_neg   = w_signed & a[N-1];
    assign w_b_neg   = w_signed & b[N-1];
    assign w_a_mag   = w_a_neg ? (~a + c_one) : a;
    assign w_b_mag   = w_b_neg ? (~b + c_one) : b;

    assign w_b_zero  = (b == '0);
    assign w_ovf     = w_signed & (a == c_min) & (b == '1);
    assign w_special = w_b_zero | w_ovf;

    // Divide-by-zero takes priority: -2^(N-1) / 0 is a divide-by-zero, not overflow
    always_comb begin
        w_special_result = '0;
        if (w_b_zero)
            w_special_result = w_rem_op ? a : '1;
        else
            w_special_result = w_rem_op ? '0 : a;
    end

    // ------------------------------------------------------------------
    // One restoring-division step: trial = {rem, next dividend bit} - |b|
    // ------------------------------------------------------------------
    assign w_shifted = {r_rem, r_quo[N-1]};

    div_unit_adder #(
        .W (N + 1)
    ) u_trial_sub (
        .i_a    (w_shifted),
        .i_b    (~{1'b0, r_div}),
        .i_c_in (1'b1),
        .o_sum  (w_trial)
    );

    // Operands stay below 2^N, so the top bit of the N+1-bit difference is its sign
    assign w_q_bit    = ~w_trial[N];
    assign w_rem_next = w_q_bit ? w_trial[N-1:0] : w_shifted[N-1:0];
    assign w_quo_next = {r_quo[N-2:0], w_q_bit};
    assign w_last     = (r_count == c_last);

    always_comb begin
        w_fix_result = '0;
        if (r_is_rem)
            w_fix_result = r_neg_r ? (~w_rem_next + c_one) : w_rem_next;
        else
            w_fix_result = r_neg_q ? (~w_quo_next + c_one) : w_quo_next;
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next_state = w_special ? ST_DONE : ST_CALC;
            ST_CALC: if (w_last)   w_next_state = ST_DONE;
            ST_DONE: if (out_ready) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_result <= '0;
            r_dbz    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_rem <= 1'b0;
            r_count  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_count  <= '0;
                        r_is_rem <= w_rem_op;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_rem    <= '0;
                        r_quo    <= w_a_mag;
                        r_div    <= w_b_mag;
                        if (w_special) begin
                            r_result <= w_special_result;
                            r_dbz    <= w_b_zero;
                        end
                    end
                end
                ST_CALC: begin
                    r_rem   <= w_rem_next;
                    r_quo   <= w_quo_next;
                    r_count <= r_count + c_cnt_one;
                    if (w_last) begin
                        r_result <= w_fix_result;
                        r_dbz    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid        = (r_state == ST_DONE);
    assign result           = r_result;
    assign div_by_zero_flag = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_div_unit                                                |
// | Description : Directed, table-driven self-checking bench for div_unit.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_div_unit;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [1:0]   div_control = 2'b00;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] result;
    logic         div_by_zero_flag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [1:0]   ctl;
        logic [N-1:0] res;
        logic         dbz;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    div_unit #(.N(N)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .a                (a),
        .b                (b),
        .div_control      (div_control),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .result           (result),
        .div_by_zero_flag (div_by_zero_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Waits for in_ready, presents the request and returns just after the accept edge
    task automatic issue(input string name, input logic [N-1:0] ta, input logic [N-1:0] tb,
                         input logic [1:0] ctl);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check({name, "_ready"}, N'(in_ready), N'(1));
        a = ta;
        b = tb;
        div_control = ctl;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~ta;
        b = '0;
        div_control = ~ctl;
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_drained"}, N'(out_valid), N'(0));
    endtask

    task automatic run_op(input vec_t v);
        int lat;
        issue(v.name, v.a, v.b, v.ctl);
        wait_result(lat);
        check({v.name, "_lat"}, N'(lat), N'(v.lat));
        check({v.name, "_res"}, result, v.res);
        check({v.name, "_dbz"}, N'(div_by_zero_flag), N'(v.dbz));
        consume(v.name);
    endtask

    initial begin
        logic [N-1:0] held;
        int lat;
        int seen;

        vecs.push_back('{"div_100_7",       32'd100,        32'd7,          2'b00, 32'd14,         1'b0, 33});
        vecs.push_back('{"rem_100_7",       32'd100,        32'd7,          2'b10, 32'd2,          1'b0, 33});
        vecs.push_back('{"div_m7_2",        32'hFFFFFFF9,   32'd2,          2'b00, 32'hFFFFFFFD,   1'b0, 33});
        vecs.push_back('{"rem_m7_2",        32'hFFFFFFF9,   32'd2,          2'b10, 32'hFFFFFFFF,   1'b0, 33});
        vecs.push_back('{"divu_fff9_2",     32'hFFFFFFF9,   32'd2,          2'b01, 32'h7FFFFFFC,   1'b0, 33});
        vecs.push_back('{"div_5_0",         32'd5,          32'd0,          2'b00, 32'hFFFFFFFF,   1'b1, 1});
        vecs.push_back('{"rem_5_0",         32'd5,          32'd0,          2'b10, 32'd5,          1'b1, 1});
        vecs.push_back('{"divu_5_0",        32'd5,          32'd0,          2'b01, 32'hFFFFFFFF,   1'b1, 1});
        vecs.push_back('{"remu_5_0",        32'd5,          32'd0,          2'b11, 32'd5,          1'b1, 1});
        vecs.push_back('{"div_ovf",         32'h80000000,   32'hFFFFFFFF,   2'b00, 32'h80000000,   1'b0, 1});
        vecs.push_back('{"rem_ovf",         32'h80000000,   32'hFFFFFFFF,   2'b10, 32'd0,          1'b0, 1});
        vecs.push_back('{"divu_min_m1",     32'h80000000,   32'hFFFFFFFF,   2'b01, 32'd0,          1'b0, 33});
        vecs.push_back('{"remu_min_m1",     32'h80000000,   32'hFFFFFFFF,   2'b11, 32'h80000000,   1'b0, 33});
        vecs.push_back('{"div_7_m2",        32'd7,          32'hFFFFFFFE,   2'b00, 32'hFFFFFFFD,   1'b0, 33});
        vecs.push_back('{"rem_7_m2",        32'd7,          32'hFFFFFFFE,   2'b10, 32'd1,          1'b0, 33});
        vecs.push_back('{"div_m100_m7",     32'hFFFFFF9C,   32'hFFFFFFF9,   2'b00, 32'd14,         1'b0, 33});
        vecs.push_back('{"rem_m100_m7",     32'hFFFFFF9C,   32'hFFFFFFF9,   2'b10, 32'hFFFFFFFE,   1'b0, 33});
        vecs.push_back('{"divu_max_1",      32'hFFFFFFFF,   32'd1,          2'b01, 32'hFFFFFFFF,   1'b0, 33});
        vecs.push_back('{"remu_max_1",      32'hFFFFFFFF,   32'd1,          2'b11, 32'd0,          1'b0, 33});
        vecs.push_back('{"div_0_5",         32'd0,          32'd5,          2'b00, 32'd0,          1'b0, 33});
        vecs.push_back('{"div_min_2",       32'h80000000,   32'd2,          2'b00, 32'hC0000000,   1'b0, 33});
        vecs.push_back('{"remu_1000_33",    32'd1000,       32'd33,         2'b11, 32'd10,         1'b0, 33});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", N'(out_valid), N'(0));
        check("rst_result", result, '0);
        check("rst_dbz", N'(div_by_zero_flag), N'(0));
        check("rst_in_ready", N'(in_ready), N'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", N'(in_ready), N'(1));

        foreach (vecs[i]) run_op(vecs[i]);

        // Back-pressure: result held stable for 5 cycles, no new request taken
        issue("hold", 32'd100, 32'd7, 2'b00);
        wait_result(lat);
        check("hold_lat", N'(lat), N'(33));
        held = result;
        check("hold_res", held, 32'd14);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_valid", N'(out_valid), N'(1));
            check("hold_in_ready", N'(in_ready), N'(0));
            check("hold_stable", result, held);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = 32'd9;
        b = 32'd3;
        div_control = 2'b01;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("release_out_valid", N'(out_valid), N'(0));
        check("release_in_ready", N'(in_ready), N'(1));
        @(posedge clk);
        #1;
        check("release_no_accept", N'(in_ready), N'(1));

        // Reset in the middle of CALC abandons the operation
        issue("abort", 32'd100, 32'd7, 2'b00);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_rst_in_ready", N'(in_ready), N'(0));
        @(posedge clk);
        #1;
        check("abort_out_valid", N'(out_valid), N'(0));
        check("abort_result", result, '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_in_ready", N'(in_ready), N'(1));
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("abort_no_result", N'(seen), N'(0));
        run_op('{"divu_9_3", 32'd9, 32'd3, 2'b01, 32'd3, 1'b0, 33});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
